// File: rtl/sha2_pkg.sv
// Shared constants and types for the SHA-2 padding and block-processing datapath.
package sha2_pkg;

    localparam int unsigned SHA256_WORD_W  = 32;
    localparam int unsigned SHA256_BLOCK_W = 512;
    localparam int unsigned SHA256_WORDS   = 16;

    localparam logic [7:0]  PAD_MARKER  = 8'h80;
    localparam int unsigned LEN_SLOT_HI = 14;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT
    } pad_state_e;

endpackage

// File: rtl/sha2_last_word_pad.sv
// Masks the bytes of a message's final word beyond its valid count and inserts the 0x80 marker,
// or reports that the marker must go into the next word when the final word is full.
module sha2_last_word_pad
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    localparam int unsigned NB    = WORD_W / 8,
    localparam int unsigned CNT_W = $clog2(NB) + 1
) (
    input  logic [WORD_W-1:0] data,
    input  logic [CNT_W-1:0]  nbytes,
    output logic [WORD_W-1:0] word,
    output logic              marker_pending
);

    int unsigned n;

    always_comb begin
        n = 32'(nbytes);
        // Counts above a full word are treated as a full word.
        if (n > NB) begin
            n = NB;
        end
        word = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < n) begin
                word[WORD_W-1-8*i -: 8] = data[WORD_W-1-8*i -: 8];
            end else if (i == n) begin
                word[WORD_W-1-8*i -: 8] = PAD_MARKER;
            end
        end
        marker_pending = (n == NB);
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects 32-bit message words, appends marker, zero fill and the
// 64-bit bit length, and hands out complete 512-bit blocks over a valid/ready handshake.
module sha256_padder
    import sha2_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SHA256_WORD_W-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [2:0]                in_bytes,
    output logic [SHA256_BLOCK_W-1:0] blk_data,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      blk_first,
    output logic                      blk_last
);

    localparam int unsigned IDX_W = $clog2(SHA256_WORDS);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(SHA256_WORDS - 1);
    localparam idx_t HI_IDX   = idx_t'(LEN_SLOT_HI);

    pad_state_e               state_q, state_d;
    pad_state_e               ret_q, ret_d;
    idx_t                     widx_q, widx_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     mp_q, mp_d;
    logic                     hi_done_q, hi_done_d;
    logic                     first_q, first_d;
    logic                     last_q, last_d;
    logic [SHA256_WORD_W-1:0] buf_q [SHA256_WORDS];
    logic [SHA256_WORD_W-1:0] buf_d [SHA256_WORDS];

    logic [SHA256_WORD_W-1:0] last_word;
    logic                     last_mp;
    logic [2:0]               bytes_eff;
    logic [5:0]               len_add;
    logic [63:0]              len64;
    logic                     in_fire;
    logic                     blk_fire;

    sha2_last_word_pad #(
        .WORD_W(SHA256_WORD_W)
    ) u_last_pad (
        .data          (in_data),
        .nbytes        (in_bytes),
        .word          (last_word),
        .marker_pending(last_mp)
    );

    assign bytes_eff = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign len_add   = in_last ? {bytes_eff, 3'b000} : 6'd32;
    assign in_fire   = in_valid && in_ready;
    assign blk_fire  = blk_valid && blk_ready;

    // Length field is always 64 bits; counter bits above LEN_W read as zero.
    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = len_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            ret_q     <= FILL;
            widx_q    <= '0;
            len_q     <= '0;
            mp_q      <= 1'b0;
            hi_done_q <= 1'b0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            buf_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            widx_q    <= widx_d;
            len_q     <= len_d;
            mp_q      <= mp_d;
            hi_done_q <= hi_done_d;
            first_q   <= first_d;
            last_q    <= last_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        widx_d    = widx_q;
        len_d     = len_q;
        mp_d      = mp_q;
        hi_done_d = hi_done_q;
        first_d   = first_q;
        last_d    = last_q;
        buf_d     = buf_q;

        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    buf_d[widx_q] = in_last ? last_word : in_data;
                    len_d         = len_q + LEN_W'(len_add);
                    if (in_last) begin
                        mp_d = last_mp;
                    end
                    if (widx_q == LAST_IDX) begin
                        state_d = EMIT;
                        ret_d   = in_last ? PAD : FILL;
                        last_d  = 1'b0;
                    end else begin
                        widx_d = widx_q + 1'b1;
                        if (in_last) begin
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (widx_q == HI_IDX && !mp_q) begin
                    buf_d[widx_q] = len64[63:32];
                    hi_done_d     = 1'b1;
                    widx_d        = widx_q + 1'b1;
                end else if (widx_q == LAST_IDX && hi_done_q) begin
                    buf_d[widx_q] = len64[31:0];
                    state_d       = EMIT;
                    last_d        = 1'b1;
                end else begin
                    buf_d[widx_q] = mp_q ? {PAD_MARKER, 24'h0} : '0;
                    mp_d          = 1'b0;
                    if (widx_q == LAST_IDX) begin
                        state_d = EMIT;
                        ret_d   = PAD;
                        last_d  = 1'b0;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (blk_fire) begin
                    widx_d    = '0;
                    buf_d     = '{default: '0};
                    first_d   = 1'b0;
                    hi_done_d = 1'b0;
                    if (last_q) begin
                        state_d = FILL;
                        len_d   = '0;
                        first_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == FILL) && !rst;
        blk_valid = (state_q == EMIT);
        blk_first = first_q;
        blk_last  = last_q;
        blk_data  = '0;
        if (state_q == EMIT) begin
            for (int i = 0; i < SHA256_WORDS; i++) begin
                blk_data[SHA256_BLOCK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W] = buf_q[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized scoreboard bench for sha256_padder; expected blocks come from a byte-level
// padding model of the message.
module tb_sha256_padder;

    typedef logic [7:0] msg_t[$];
    typedef struct packed {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         blk_first;
    logic         blk_last;

    blk_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 2;  // 0 random, 1 hold low, 2 always high

    always #5 clk = ~clk;

    sha256_padder #(
        .LEN_W(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_bytes (in_bytes),
        .blk_data (blk_data),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_first(blk_first),
        .blk_last (blk_last)
    );

    function automatic void chk(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit big-endian bit count.
    function automatic void push_expected(input msg_t m);
        logic [7:0]  p[$];
        logic [63:0] bitlen;
        int          nblk;
        blk_t        e;
        p = m;
        bitlen = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bitlen[k*8 +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[b*64+j];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            sb_q.push_back(e);
        end
    endfunction

    function automatic msg_t rand_msg(input int n);
        msg_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       blk_ready = 1'($urandom_range(0, 1));
            1:       blk_ready = 1'b0;
            default: blk_ready = 1'b1;
        endcase
    end

    // Monitor: every block transfer is compared against the head of the scoreboard.
    always @(negedge clk) begin
        blk_t e;
        if (!rst && blk_valid && blk_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got %h expected no block", blk_data);
            end else begin
                e = sb_q.pop_front();
                chk("blk_data", blk_data, e.data);
                chk1("blk_first", blk_first, e.first);
                chk1("blk_last", blk_last, e.last);
            end
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (in_ready) break;
            if (cyc >= 500) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input msg_t m);
        int n;
        int nw;
        n  = m.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int          nb;
            logic [2:0]  ib;
            d  = $urandom;  // bytes past the valid count stay as garbage
            nb = (w == nw - 1) ? n - 4 * w : 4;
            for (int b = 0; b < nb; b++) d[31-8*b -: 8] = m[4*w+b];
            ib = 3'(nb);
            if (w == nw - 1 && nb == 4 && $urandom_range(0, 3) == 0) ib = 3'($urandom_range(4, 7));
            if (w != nw - 1) ib = 3'($urandom);
            while ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_word(d, w == nw - 1, ib);
        end
    endtask

    task automatic wait_drain();
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
            if (cyc >= 3000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d blocks pending expected 0", sb_q.size());
                sb_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (blk_valid) break;
            if (cyc >= 500) begin
                checks++;
                errors++;
                $display("FAIL blk_valid_timeout: got blk_valid=0 expected 1");
                break;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_blk_valid"}, blk_valid, 1'b0);
        chk1({tag, "_blk_first"}, blk_first, 1'b1);
        chk1({tag, "_blk_last"}, blk_last, 1'b0);
        chk({tag, "_blk_data"}, blk_data, 512'h0);
    endtask

    initial begin
        msg_t m;
        int   lens[6] = '{55, 56, 63, 64, 119, 120};
        msg_t abc;
        abc = {8'h61, 8'h62, 8'h63};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("in_ready_during_reset", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // Directed messages
        push_expected(abc);
        send_msg(abc);
        wait_drain();
        m = {};
        push_expected(m);
        send_msg(m);
        wait_drain();
        foreach (lens[i]) begin
            m = rand_msg(lens[i]);
            push_expected(m);
            send_msg(m);
            wait_drain();
        end

        // Backpressure: block held for 10 cycles
        ready_mode = 1;
        @(posedge clk);
        #1;
        push_expected(abc);
        send_msg(abc);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("bp_blk_valid", blk_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk("bp_blk_data", blk_data, sb_q[0].data);
        end
        ready_mode = 2;
        wait_drain();
        m = rand_msg(10);
        push_expected(m);
        send_msg(m);
        wait_drain();

        // Reset after 7 words of a message
        ready_mode = 0;
        for (int i = 0; i < 7; i++) drive_word($urandom, 1'b0, 3'($urandom));
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_msg_reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("mid_msg_reset");
        @(posedge clk);
        #1;
        push_expected(abc);
        send_msg(abc);
        wait_drain();

        // Reset while a block is waiting in EMIT
        ready_mode = 1;
        @(posedge clk);
        #1;
        m = rand_msg(20);
        push_expected(m);
        send_msg(m);
        wait_valid();
        @(posedge clk);
        #1 rst = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 2;
        @(negedge clk);
        check_reset_state("mid_emit_reset");
        @(posedge clk);
        #1;
        push_expected(abc);
        send_msg(abc);
        wait_drain();

        // Random back-to-back messages with random downstream readiness
        ready_mode = 0;
        repeat (25) begin
            m = rand_msg($urandom_range(0, 200));
            push_expected(m);
            send_msg(m);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
